csr_access_ctrl: RTL and testbench
==================================

// Module: csr_access_ctrl
// PURPOSE
//   Sequences CSR instructions (CSRRW/CSRRS/CSRRC/read) into a read-modify-write on the csr register file.
//   Arbitrates the single CSR port between the core pipeline and the debug/simulation requester.
//   Sits between the execute stage / debug port and csr; drives its raddr_i, csr_waddr_i, csr_val_i and csr_valid_i.
// PARAMETERS
//   DataWidth     32   data path width in bits (32 or 64)
//   CsrAddrWidth  12   CSR address width
// PORTS
//   clk_i             in   1    system clock
//   rstn_i            in   1    asynchronous active-low reset
//   core_req_valid_i  in   1    core request valid
//   core_req_ready_o  out  1    core request accepted this cycle
//   core_op_i         in   2    00 RW, 01 RS, 10 RC, 11 read-only
//   core_addr_i       in   CsrAddrWidth  core CSR address
//   core_wdata_i      in   DataWidth     core operand (rs1 value / immediate)
//   core_rsp_valid_o  out  1    core response pulse
//   core_rdata_o      out  DataWidth     old CSR value returned to core
//   dbg_req_valid_i / dbg_req_ready_o / dbg_op_i / dbg_addr_i / dbg_wdata_i   same as core_*, debug requester
//   dbg_rsp_valid_o / dbg_rdata_o        same as core_*, debug requester
//   csr_raddr_o       out  CsrAddrWidth  to csr raddr_i
//   csr_rval_i        in   DataWidth     from csr csr_val_o (combinational read)
//   csr_waddr_o       out  CsrAddrWidth  to csr csr_waddr_i
//   csr_wval_o        out  DataWidth     to csr csr_val_i
//   csr_wvalid_o      out  1    to csr csr_valid_i, single-cycle write strobe
//   busy_o            out  1    FSM not in IDLE
// BEHAVIOUR
//   Reset (rstn_i low, async): state=IDLE, last_grant=DBG, addr_q/wdata_q/rdata_q/op_q=0; all *_valid_o, ready_o,
//     busy_o=0; csr_raddr_o=csr_waddr_o=csr_wval_o=0; any in-flight op is dropped (no write, no response).
//   FSM: IDLE -> READ -> WRITE -> RESP -> IDLE; READ -> RESP when the write is skipped.
//   IDLE: grant = only valid requester; if both valid, the one NOT in last_grant (round-robin; core wins first after reset).
//     <x>_req_ready_o = (state==IDLE) & grant==x & <x>_req_valid_i; handshake = valid & ready.
//     On handshake: latch op, addr, wdata, grant; last_grant<=grant; ->READ. Ready low in every other state.
//   READ (1 cycle): rdata_q <= csr_rval_i. Skip write if op==11, or op in {RS,RC} with wdata_q==0 (RISC-V rule) -> RESP;
//     otherwise -> WRITE.
//   WRITE (1 cycle): csr_wvalid_o=1; csr_wval_o = RW: wdata_q; RS: rdata_q|wdata_q; RC: rdata_q&~wdata_q. ->RESP.
//   RESP (1 cycle): granted <x>_rsp_valid_o=1, <x>_rdata_o=rdata_q (value before write); other requester rsp 0. ->IDLE.
//   csr_raddr_o = csr_waddr_o = addr_q in all states; csr_wval_o = 0 outside WRITE.
//   rdata_o holds its last value between responses; responses cannot be back-pressured.
//   Latency (handshake = cycle 0): write strobe cycle 2, response cycle 3; skipped write: response cycle 2.
//   Throughput: one op per 4 cycles (3 if write skipped); a held request is accepted in the IDLE cycle after RESP.
//   Write data width is DataWidth; no truncation or extension; address is passed through unmodified.
//   Requests arriving while busy are neither lost nor accepted: the requester holds valid until ready.
// TESTING
//   Core RS addr 0xC00 wdata 0x1, csr_rval_i=0x10 -> cycle 2 wvalid=1 waddr=0xC00 wval=0x11; cycle 3 rsp rdata=0x10.
//   Core RW wdata 0xDEADBEEF, csr_rval_i=0x5 -> wval=0xDEADBEEF one cycle; rsp rdata=0x5 at cycle 3.
//   Core RC wdata 0 / op 11 read, csr_rval_i=0x1234 -> no wvalid pulse; rsp rdata=0x1234 at cycle 2.
//   Core+dbg valid together after reset, held -> core served first, dbg next, then alternating; each rsp to its own port.
//   Assert rstn_i low during WRITE -> wvalid and busy drop immediately, no rsp; after release a core RS completes normally.
//   Core valid held for 3 RW ops -> handshakes at cycles 0,4,8; exactly one wvalid and one rsp per op; dbg rsp stays 0.

Source files
------------

// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: arbitrates core/debug CSR requests into a read-modify-write on the CSR file.
// Revision: 1.0
`default_nettype none

module csr_access_ctrl #(
  parameter int DataWidth    = 32,
  parameter int CsrAddrWidth = 12
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    core_req_valid_i,
  output logic                    core_req_ready_o,
  input  logic [1:0]              core_op_i,
  input  logic [CsrAddrWidth-1:0] core_addr_i,
  input  logic [DataWidth-1:0]    core_wdata_i,
  output logic                    core_rsp_valid_o,
  output logic [DataWidth-1:0]    core_rdata_o,
  input  logic                    dbg_req_valid_i,
  output logic                    dbg_req_ready_o,
  input  logic [1:0]              dbg_op_i,
  input  logic [CsrAddrWidth-1:0] dbg_addr_i,
  input  logic [DataWidth-1:0]    dbg_wdata_i,
  output logic                    dbg_rsp_valid_o,
  output logic [DataWidth-1:0]    dbg_rdata_o,
  output logic [CsrAddrWidth-1:0] csr_raddr_o,
  input  logic [DataWidth-1:0]    csr_rval_i,
  output logic [CsrAddrWidth-1:0] csr_waddr_o,
  output logic [DataWidth-1:0]    csr_wval_o,
  output logic                    csr_wvalid_o,
  output logic                    busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [1:0] OP_RW = 2'b00;
  localparam logic [1:0] OP_RS = 2'b01;
  localparam logic [1:0] OP_RC = 2'b10;

  state_e                  state_q, state_d;
  logic                    last_dbg_q, last_dbg_d;
  logic                    grant_dbg_q, grant_dbg_d;
  logic [1:0]              op_q, op_d;
  logic [CsrAddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0]    wdata_q, wdata_d;
  logic [DataWidth-1:0]    rdata_q, rdata_d;
  logic [DataWidth-1:0]    core_hold_q, core_hold_d;
  logic [DataWidth-1:0]    dbg_hold_q, dbg_hold_d;

  logic w_grant_dbg;
  logic w_hs;
  logic w_skip;
  logic w_resp;

  // Round-robin on contention: the requester not served last wins.
  assign w_grant_dbg = (core_req_valid_i && dbg_req_valid_i) ? ~last_dbg_q : dbg_req_valid_i;

  assign core_req_ready_o = (state_q == IDLE) && !w_grant_dbg && core_req_valid_i;
  assign dbg_req_ready_o  = (state_q == IDLE) &&  w_grant_dbg && dbg_req_valid_i;
  assign w_hs             = core_req_ready_o || dbg_req_ready_o;

  // Set/clear with a zero operand must not write (side-effect-free CSR read).
  assign w_skip = (op_q == 2'b11) || ((op_q != OP_RW) && (wdata_q == '0));
  assign w_resp = (state_q == RESP);

  assign busy_o           = (state_q != IDLE);
  assign csr_raddr_o      = addr_q;
  assign csr_waddr_o      = addr_q;
  assign csr_wvalid_o     = (state_q == WRITE);
  assign core_rsp_valid_o = w_resp && !grant_dbg_q;
  assign dbg_rsp_valid_o  = w_resp &&  grant_dbg_q;
  assign core_rdata_o     = core_rsp_valid_o ? rdata_q : core_hold_q;
  assign dbg_rdata_o      = dbg_rsp_valid_o  ? rdata_q : dbg_hold_q;

  always_comb begin
    csr_wval_o = '0;
    if (state_q == WRITE) begin
      case (op_q)
        OP_RW:   csr_wval_o = wdata_q;
        OP_RS:   csr_wval_o = rdata_q | wdata_q;
        OP_RC:   csr_wval_o = rdata_q & ~wdata_q;
        default: csr_wval_o = '0;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    last_dbg_d  = last_dbg_q;
    grant_dbg_d = grant_dbg_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    core_hold_d = core_hold_q;
    dbg_hold_d  = dbg_hold_q;
    case (state_q)
      IDLE: begin
        if (w_hs) begin
          grant_dbg_d = w_grant_dbg;
          last_dbg_d  = w_grant_dbg;
          op_d        = w_grant_dbg ? dbg_op_i    : core_op_i;
          addr_d      = w_grant_dbg ? dbg_addr_i  : core_addr_i;
          wdata_d     = w_grant_dbg ? dbg_wdata_i : core_wdata_i;
          state_d     = READ;
        end
      end
      READ: begin
        rdata_d = csr_rval_i;
        state_d = w_skip ? RESP : WRITE;
      end
      WRITE: begin
        state_d = RESP;
      end
      RESP: begin
        if (grant_dbg_q) dbg_hold_d  = rdata_q;
        else             core_hold_d = rdata_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      last_dbg_q  <= 1'b1;
      grant_dbg_q <= 1'b0;
      op_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      core_hold_q <= '0;
      dbg_hold_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_dbg_q  <= last_dbg_d;
      grant_dbg_q <= grant_dbg_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      core_hold_q <= core_hold_d;
      dbg_hold_q  <= dbg_hold_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_csr_access_ctrl.sv
// tb_csr_access_ctrl: directed self-checking bench for csr_access_ctrl.
// Revision: 1.0
`default_nettype none

module tb_csr_access_ctrl;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        core_req_valid_i = 1'b0;
  logic        core_req_ready_o;
  logic [1:0]  core_op_i = '0;
  logic [11:0] core_addr_i = '0;
  logic [31:0] core_wdata_i = '0;
  logic        core_rsp_valid_o;
  logic [31:0] core_rdata_o;
  logic        dbg_req_valid_i = 1'b0;
  logic        dbg_req_ready_o;
  logic [1:0]  dbg_op_i = '0;
  logic [11:0] dbg_addr_i = '0;
  logic [31:0] dbg_wdata_i = '0;
  logic        dbg_rsp_valid_o;
  logic [31:0] dbg_rdata_o;
  logic [11:0] csr_raddr_o;
  logic [31:0] csr_rval_i = '0;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wval_o;
  logic        csr_wvalid_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_err = 0;

  csr_access_ctrl #(.DataWidth(32), .CsrAddrWidth(12)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .core_req_valid_i(core_req_valid_i), .core_req_ready_o(core_req_ready_o),
    .core_op_i(core_op_i), .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
    .core_rsp_valid_o(core_rsp_valid_o), .core_rdata_o(core_rdata_o),
    .dbg_req_valid_i(dbg_req_valid_i), .dbg_req_ready_o(dbg_req_ready_o),
    .dbg_op_i(dbg_op_i), .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i),
    .dbg_rsp_valid_o(dbg_rsp_valid_o), .dbg_rdata_o(dbg_rdata_o),
    .csr_raddr_o(csr_raddr_o), .csr_rval_i(csr_rval_i),
    .csr_waddr_o(csr_waddr_o), .csr_wval_o(csr_wval_o),
    .csr_wvalid_o(csr_wvalid_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Move to the sampling point one time unit after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Runs one request from an idle window; returns in the idle window after the response.
  task automatic run_op(input bit dbg, input logic [1:0] op, input logic [11:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rval,
                        input bit skip, input logic [31:0] exp_wval);
    csr_rval_i = rval;
    if (dbg) begin
      dbg_req_valid_i = 1'b1; dbg_op_i = op; dbg_addr_i = addr; dbg_wdata_i = wdata;
    end else begin
      core_req_valid_i = 1'b1; core_op_i = op; core_addr_i = addr; core_wdata_i = wdata;
    end
    #1;
    chk("ready_own", dbg ? dbg_req_ready_o : core_req_ready_o, 1'b1);
    chk("ready_other", dbg ? core_req_ready_o : dbg_req_ready_o, 1'b0);
    tick();
    core_req_valid_i = 1'b0;
    dbg_req_valid_i  = 1'b0;
    #1;
    chk("read_busy", busy_o, 1'b1);
    chk("read_ready", core_req_ready_o | dbg_req_ready_o, 1'b0);
    chk("read_wvalid", csr_wvalid_o, 1'b0);
    chk("read_raddr", csr_raddr_o, addr);
    tick();
    if (!skip) begin
      chk("wr_wvalid", csr_wvalid_o, 1'b1);
      chk("wr_waddr", csr_waddr_o, addr);
      chk("wr_wval", csr_wval_o, exp_wval);
      chk("wr_rsp", core_rsp_valid_o | dbg_rsp_valid_o, 1'b0);
      tick();
    end
    chk("rsp_wvalid", csr_wvalid_o, 1'b0);
    chk("rsp_wval_zero", csr_wval_o, 32'h0);
    chk("rsp_own", dbg ? dbg_rsp_valid_o : core_rsp_valid_o, 1'b1);
    chk("rsp_other", dbg ? core_rsp_valid_o : dbg_rsp_valid_o, 1'b0);
    chk("rsp_rdata", dbg ? dbg_rdata_o : core_rdata_o, rval);
    tick();
    chk("idle_rsp", core_rsp_valid_o | dbg_rsp_valid_o, 1'b0);
    chk("idle_busy", busy_o, 1'b0);
    chk("idle_rdata_hold", dbg ? dbg_rdata_o : core_rdata_o, rval);
  endtask

  initial begin
    int rsp_port[8];
    int rsp_cyc[8];
    int nrsp;
    int hs_cyc[4];
    int nhs, nwv, ncr, ndr, nboth;

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_ready", core_req_ready_o | dbg_req_ready_o, 1'b0);
    chk("rst_wvalid", csr_wvalid_o, 1'b0);
    chk("rst_waddr", csr_waddr_o, 12'h0);
    chk("rst_wval", csr_wval_o, 32'h0);
    chk("rst_rsp", core_rsp_valid_o | dbg_rsp_valid_o, 1'b0);
    chk("rst_rdata", core_rdata_o | dbg_rdata_o, 32'h0);
    rstn_i = 1'b1;
    tick();

    // Basic RMW and skip cases
    run_op(1'b0, 2'b01, 12'hC00, 32'h1, 32'h10, 1'b0, 32'h11);
    run_op(1'b0, 2'b00, 12'h300, 32'hDEADBEEF, 32'h5, 1'b0, 32'hDEADBEEF);
    run_op(1'b0, 2'b10, 12'h341, 32'h0, 32'h1234, 1'b1, 32'h0);
    run_op(1'b0, 2'b11, 12'h342, 32'hFFFF, 32'h1234, 1'b1, 32'h0);
    run_op(1'b0, 2'b10, 12'h304, 32'h0000_00F0, 32'h0000_0FFF, 1'b0, 32'h0000_0F0F);
    run_op(1'b1, 2'b01, 12'h7B0, 32'h0, 32'hABCD, 1'b1, 32'h0);
    run_op(1'b1, 2'b00, 12'h7B1, 32'h8000_0001, 32'h77, 1'b0, 32'h8000_0001);

    // Contention after a fresh reset: core first, then alternate
    rstn_i = 1'b0;
    #1;
    rstn_i = 1'b1;
    tick();
    csr_rval_i = 32'h55;
    core_op_i = 2'b00; core_addr_i = 12'h100; core_wdata_i = 32'h1;
    dbg_op_i  = 2'b00; dbg_addr_i  = 12'h200; dbg_wdata_i  = 32'h2;
    core_req_valid_i = 1'b1;
    dbg_req_valid_i  = 1'b1;
    #1;
    nrsp = 0;
    nboth = 0;
    for (int c = 0; c < 20; c++) begin
      if (core_rsp_valid_o && dbg_rsp_valid_o) nboth++;
      if ((core_rsp_valid_o || dbg_rsp_valid_o) && nrsp < 8) begin
        rsp_port[nrsp] = dbg_rsp_valid_o ? 1 : 0;
        rsp_cyc[nrsp]  = c;
        nrsp++;
      end
      tick();
      #1;
    end
    core_req_valid_i = 1'b0;
    dbg_req_valid_i  = 1'b0;
    chk("arb_nrsp", nrsp, 5);
    chk("arb_both", nboth, 0);
    if (nrsp >= 4) begin
      chk("arb_port0", rsp_port[0], 0);
      chk("arb_port1", rsp_port[1], 1);
      chk("arb_port2", rsp_port[2], 0);
      chk("arb_port3", rsp_port[3], 1);
      chk("arb_cyc0", rsp_cyc[0], 3);
      chk("arb_gap", rsp_cyc[3] - rsp_cyc[0], 12);
    end
    repeat (4) tick();

    // Reset asserted mid-write drops the operation
    csr_rval_i = 32'h9;
    core_op_i = 2'b00; core_addr_i = 12'h321; core_wdata_i = 32'hCAFE;
    core_req_valid_i = 1'b1;
    #1;
    chk("rw_ready", core_req_ready_o, 1'b1);
    tick();
    core_req_valid_i = 1'b0;
    tick();
    chk("rw_wvalid_pre", csr_wvalid_o, 1'b1);
    rstn_i = 1'b0;
    #1;
    chk("rw_wvalid_drop", csr_wvalid_o, 1'b0);
    chk("rw_busy_drop", busy_o, 1'b0);
    chk("rw_waddr_clr", csr_waddr_o, 12'h0);
    tick();
    rstn_i = 1'b1;
    nwv = 0; ncr = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      nwv += int'(csr_wvalid_o);
      ncr += int'(core_rsp_valid_o | dbg_rsp_valid_o);
    end
    chk("rw_no_wvalid", nwv, 0);
    chk("rw_no_rsp", ncr, 0);
    run_op(1'b0, 2'b01, 12'hC01, 32'h4, 32'h3, 1'b0, 32'h7);

    // Held core request: three RW ops back to back
    csr_rval_i = 32'h42;
    core_op_i = 2'b00; core_addr_i = 12'h340; core_wdata_i = 32'h1357;
    core_req_valid_i = 1'b1;
    #1;
    nhs = 0; nwv = 0; ncr = 0; ndr = 0;
    for (int c = 0; c < 14; c++) begin
      if (core_req_ready_o && nhs < 4) begin
        hs_cyc[nhs] = c;
        nhs++;
      end
      nwv += int'(csr_wvalid_o);
      ncr += int'(core_rsp_valid_o);
      ndr += int'(dbg_rsp_valid_o);
      tick();
      if (nhs == 3) core_req_valid_i = 1'b0;
      #1;
    end
    chk("held_nhs", nhs, 3);
    if (nhs == 3) begin
      chk("held_hs0", hs_cyc[0], 0);
      chk("held_hs1", hs_cyc[1], 4);
      chk("held_hs2", hs_cyc[2], 8);
    end
    chk("held_nwv", nwv, 3);
    chk("held_ncr", ncr, 3);
    chk("held_ndr", ndr, 0);
    chk("held_rdata", core_rdata_o, 32'h42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
